// File: rtl/phase_timer.sv
// Per-phase dwell timer: counts qualified ticks in the active one-hot phase and pulses
// phase_end when the programmable duration is reached. Durations are writable at runtime.
module phase_timer #(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 2,
  parameter logic [NUM_PHASES*CNT_W-1:0] DEFAULT_DUR = {8'd9, 8'd4, 8'd29}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_en,
  input  logic                  hold,
  input  logic [NUM_PHASES-1:0] phase_sel,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [CNT_W-1:0]      cfg_wdata,
  output logic [CNT_W-1:0]      cfg_rdata,
  output logic [NUM_PHASES-1:0] phase_end,
  output logic [CNT_W-1:0]      remain,
  output logic                  sel_err
);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_PHASES-1:0] sel_q;
  logic [CNT_W-1:0]      dur_q [NUM_PHASES];
  logic                  sel_valid, change, act;
  logic [CNT_W-1:0]      dur_act;

  assign sel_valid = $onehot(phase_sel);
  assign sel_err   = ~sel_valid;
  assign change    = (phase_sel != sel_q);
  assign act       = sel_valid & tick_en & ~hold & ~change;

  // >= rather than == so a duration lowered below the count still terminates the phase.
  always_comb begin
    phase_end = '0;
    dur_act   = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (phase_sel[i]) dur_act = dur_act | dur_q[i];
      phase_end[i] = phase_sel[i] & act & ~rst & (count_q >= dur_q[i]);
    end
  end

  always_comb begin
    if (rst || !sel_valid || (count_q > dur_act)) remain = '0;
    else                                          remain = dur_act - count_q;
  end

  always_comb begin
    cfg_rdata = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (cfg_idx == IDX_W'(i)) cfg_rdata = dur_q[i];
    end
  end

  always_comb begin
    if (!sel_valid)           count_d = '0;
    else if (change)          count_d = '0;
    else if (|phase_end)      count_d = '0;
    else if (tick_en && !hold) count_d = count_q + CNT_W'(1);
    else                      count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sel_q   <= '0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        dur_q[i] <= DEFAULT_DUR[i*CNT_W +: CNT_W];
      end
    end else begin
      count_q <= count_d;
      sel_q   <= phase_sel;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) dur_q[i] <= cfg_wdata;
      end
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Scenario bench for phase_timer: each task pushes per-cycle expectations of
// {phase_end, remain, sel_err, cfg_rdata} and pops them against the DUT on the falling edge.
module tb_phase_timer;

  logic       clk = 1'b0;
  logic       rst, tick_en, hold, cfg_we;
  logic [2:0] phase_sel;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_wdata, cfg_rdata, remain;
  logic [2:0] phase_end;
  logic       sel_err;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] sb[$];
  logic [19:0] got, want;

  always #5 clk = ~clk;

  phase_timer dut (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .hold     (hold),
    .phase_sel(phase_sel),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .phase_end(phase_end),
    .remain   (remain),
    .sel_err  (sel_err)
  );

  function automatic logic [19:0] mk(input logic [2:0] pe, input logic [7:0] rem,
                                     input logic err, input logic [7:0] rd);
    return {pe, rem, err, rd};
  endfunction

  // Reset holds outputs quiet, restores defaults and ignores a concurrent config write.
  task automatic test_reset();
    logic [7:0] rd;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      rst = 1'b1; tick_en = 1'b1; hold = 1'b0;
      phase_sel = (k % 2 == 1) ? 3'b011 : 3'b001;
      cfg_idx = (k == 4) ? 2'd2 : 2'(k);
      cfg_we = (k == 2); cfg_wdata = 8'd99;
      case (k)
        0: rd = 8'd29;
        1: rd = 8'd4;
        2: rd = 8'd9;
        3: rd = 8'd0;
        default: rd = 8'd9;
      endcase
      sb.push_back(mk(3'b000, 8'd0, (k % 2 == 1), rd));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_defaults();
    for (int k = 0; k <= 31; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; phase_sel = 3'b001; cfg_idx = 2'd2; cfg_we = 1'b0; tick_en = 1'b1; hold = 1'b0;
      sb.push_back(mk((k == 30) ? 3'b001 : 3'b000,
                      (k == 0 || k == 31) ? 8'd29 : 8'(30 - k), 1'b0, 8'd9));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL defaults k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  // k=-1 is an invalid-select cycle that parks the counter at 0 before the scenario.
  task automatic test_tick_strobe();
    for (int k = -1; k <= 21; k++) begin
      @(posedge clk); #1;
      phase_sel = (k < 0) ? 3'b000 : 3'b010; cfg_idx = 2'd2; cfg_we = 1'b0; hold = 1'b0;
      tick_en = (k >= 0) && (k % 4 == 0);
      if (k < 0) sb.push_back(mk(3'b000, 8'd0, 1'b1, 8'd9));
      else sb.push_back(mk((k == 20) ? 3'b010 : 3'b000,
                           (k == 0 || k == 21) ? 8'd4 : 8'(4 - (k - 1) / 4), 1'b0, 8'd9));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL tick_strobe k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] rem;
    for (int k = -1; k <= 21; k++) begin
      @(posedge clk); #1;
      phase_sel = (k < 0) ? 3'b000 : 3'b100; cfg_idx = 2'd2; cfg_we = 1'b0; tick_en = 1'b1;
      hold = (k >= 3) && (k <= 12);
      if (k < 0)        rem = 8'd0;
      else if (k <= 1)  rem = 8'd9;
      else if (k == 2)  rem = 8'd8;
      else if (k <= 13) rem = 8'd7;
      else if (k <= 20) rem = 8'(20 - k);
      else              rem = 8'd9;
      sb.push_back(mk((k == 20) ? 3'b100 : 3'b000, rem, (k < 0), 8'd9));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_phase_change();
    logic [7:0] rem;
    for (int k = -1; k <= 20; k++) begin
      @(posedge clk); #1;
      cfg_idx = 2'd2; cfg_we = 1'b0; tick_en = 1'b1; hold = 1'b0;
      if (k < 0)                 phase_sel = 3'b000;
      else if (k <= 15)          phase_sel = 3'b001;
      else if (k <= 17 || k == 20) phase_sel = 3'b100;
      else                       phase_sel = 3'b011;
      if (k < 0 || k == 16 || k == 18 || k == 19) rem = 8'd0;
      else if (k == 17 || k == 20)               rem = 8'd9;
      else if (k == 0)                           rem = 8'd29;
      else                                       rem = 8'(30 - k);
      sb.push_back(mk(3'b000, rem, (k < 0 || k == 18 || k == 19), 8'd9));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL phase_change k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  // Lowering dur[0] below the running count ends the phase on the next act cycle.
  task automatic test_cfg_write();
    logic [7:0] rem, rd;
    for (int k = -1; k <= 16; k++) begin
      @(posedge clk); #1;
      phase_sel = (k < 0) ? 3'b000 : 3'b001; tick_en = 1'b1; hold = 1'b0;
      cfg_idx = (k == 13 || k == 14) ? 2'd3 : 2'd0;
      cfg_we = (k == 11) || (k == 13);
      cfg_wdata = (k == 11) ? 8'd3 : 8'd77;
      if (k < 0)                  rem = 8'd0;
      else if (k == 0)            rem = 8'd29;
      else if (k <= 11)           rem = 8'(30 - k);
      else if (k == 12 || k == 16) rem = 8'd0;
      else                        rem = 8'(16 - k);
      if (k <= 11)                rd = 8'd29;
      else if (k == 13 || k == 14) rd = 8'd0;
      else                        rd = 8'd3;
      sb.push_back(mk((k == 12 || k == 16) ? 3'b001 : 3'b000, rem, (k < 0), rd));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg_write k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rem, rd;
    for (int k = -1; k <= 24; k++) begin
      @(posedge clk); #1;
      phase_sel = (k < 0) ? 3'b000 : 3'b001; tick_en = 1'b1; hold = 1'b0; cfg_idx = 2'd0;
      cfg_we = (k == 0); cfg_wdata = 8'd50;
      rst = (k == 21);
      if (k < 0 || k == 21)        rem = 8'd0;
      else if (k == 0)             rem = 8'd3;
      else if (k <= 20)            rem = 8'(51 - k);
      else if (k <= 23)            rem = 8'd29;
      else                         rem = 8'd28;
      if (k <= 0)                  rd = 8'd3;
      else if (k <= 21)            rd = 8'd50;
      else                         rd = 8'd29;
      sb.push_back(mk(3'b000, rem, (k < 0), rd));
      @(negedge clk);
      got = {phase_end, remain, sel_err, cfg_rdata}; want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid k=%0d: got pe=%b rem=%0d err=%b rd=%0d, want pe=%b rem=%0d err=%b rd=%0d",
                 k, got[19:17], got[16:9], got[8], got[7:0],
                 want[19:17], want[16:9], want[8], want[7:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick_en = 1'b0; hold = 1'b0; cfg_we = 1'b0;
    phase_sel = 3'b000; cfg_idx = 2'd0; cfg_wdata = 8'd0;
    test_reset();
    test_defaults();
    test_tick_strobe();
    test_hold();
    test_phase_change();
    test_cfg_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
